// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, pipeline bundle and helpers.
// Optional test-pattern build: define VGA_TEST_PATTERN_EN.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_CW    = 4;
  localparam int unsigned VGA_LAT   = 2;
  localparam int unsigned VGA_CNT_W = 10;

  localparam int unsigned NUM_BARS  = 8;
  localparam int unsigned BAR_IDX_W = 3;

  localparam logic [2:0] BAR_BLACK   = 3'd0;
  localparam logic [2:0] BAR_BLUE    = 3'd1;
  localparam logic [2:0] BAR_GREEN   = 3'd2;
  localparam logic [2:0] BAR_CYAN    = 3'd3;
  localparam logic [2:0] BAR_RED     = 3'd4;
  localparam logic [2:0] BAR_MAGENTA = 3'd5;
  localparam logic [2:0] BAR_YELLOW  = 3'd6;
  localparam logic [2:0] BAR_WHITE   = 3'd7;

  // Flags that ride alongside a request until its colour returns.
  typedef struct packed {
`ifdef VGA_TEST_PATTERN_EN
    logic       tp;
    logic [2:0] bar;
`endif
    logic act;
    logic hs;
    logic vs;
  } pipe_t;

  function automatic int unsigned calc_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster position counters with registered active/sync flags.
// Outputs describe the coordinate presented this cycle.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CNT_W    = VGA_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             act_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             fs_o,
  output logic             ls_o
);

  localparam int unsigned H_TOTAL =
    calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL =
    calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT =
    CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT =
    CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             run_q;
  logic             act_q, hs_q, vs_q;
  logic             fs_q, ls_q;

  // Next raster position; first cycle after reset presents (0,0).
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  // Position and flags registered together so they stay aligned.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q   <= '0;
      v_q   <= '0;
      run_q <= 1'b0;
      act_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      run_q <= 1'b1;
      act_q <= (h_d < H_ACT) && (v_d < V_ACT);
      hs_q  <= (h_d >= HS_BEG) && (h_d < HS_END);
      vs_q  <= (v_d >= VS_BEG) && (v_d < VS_END);
      fs_q  <= (h_d == '0) && (v_d == '0);
      ls_q  <= (h_d == '0);
    end
  end

  assign h_o   = h_q;
  assign v_o   = v_q;
  assign act_o = act_q;
  assign hs_o  = hs_q;
  assign vs_o  = vs_q;
  assign fs_o  = fs_q;
  assign ls_o  = ls_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// VGA raster engine: request generator, latency-matched flag pipe
// and blanked output stage. Test pattern via VGA_TEST_PATTERN_EN.
module vga_pixel_pipe
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = VGA_CW,
  parameter int unsigned LAT      = VGA_LAT,
  parameter int unsigned CNT_W    = VGA_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             tp_en,
`endif
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic             req_valid,
  input  logic [CW-1:0]    pix_r,
  input  logic [CW-1:0]    pix_g,
  input  logic [CW-1:0]    pix_b,
  output logic             frame_start,
  output logic             line_start,
  output logic             VGA_HSYNC,
  output logic             VGA_VSYNC,
  output logic [CW-1:0]    VGA_R,
  output logic [CW-1:0]    VGA_G,
  output logic [CW-1:0]    VGA_B
);

  logic  raw_hs, raw_vs;
  pipe_t req_p;
  pipe_t tail;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .h_o    (req_x),
    .v_o    (req_y),
    .act_o  (req_valid),
    .hs_o   (raw_hs),
    .vs_o   (raw_vs),
    .fs_o   (frame_start),
    .ls_o   (line_start)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

  logic [CNT_W-1:0] bar_full;
  logic [2:0]       bar_idx;

  // Bar index of the requested column, clamped for blanking columns.
  always_comb begin
    bar_full = req_x / CNT_W'(BAR_W);
    bar_idx  = bar_full[2:0];
    if (bar_full > CNT_W'(BAR_WHITE)) begin
      bar_idx = BAR_WHITE;
    end
  end

  assign req_p.tp  = tp_en;
  assign req_p.bar = bar_idx;
`endif

  assign req_p.act = req_valid;
  assign req_p.hs  = raw_hs;
  assign req_p.vs  = raw_vs;

  // Flags wait LAT clocks so they meet the returning colour.
  if (LAT == 0) begin : g_nolat
    assign tail = req_p;
  end else begin : g_lat
    pipe_t pipe_q [LAT];

    // Shift flags along the latency pipe; reset leaves it blank.
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < int'(LAT); i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= req_p;
        for (int i = 1; i < int'(LAT); i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign tail = pipe_q[LAT-1];
  end

  logic [CW-1:0] col_r, col_g, col_b;

  // Colour source for the pixel now at the pipe tail.
  always_comb begin
    col_r = pix_r;
    col_g = pix_g;
    col_b = pix_b;
`ifdef VGA_TEST_PATTERN_EN
    if (tail.tp) begin
      col_r = {CW{tail.bar[2]}};
      col_g = {CW{tail.bar[1]}};
      col_b = {CW{tail.bar[0]}};
    end
`endif
  end

  // Pin register: blank outside active area, apply sync polarity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      VGA_HSYNC <= ~HS_POL;
      VGA_VSYNC <= ~VS_POL;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      VGA_HSYNC <= tail.hs ? HS_POL : ~HS_POL;
      VGA_VSYNC <= tail.vs ? VS_POL : ~VS_POL;
      VGA_R     <= tail.act ? col_r : '0;
      VGA_G     <= tail.act ? col_g : '0;
      VGA_B     <= tail.act ? col_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench: small 14x8 mode, LAT=0 and LAT=3 instances,
// mid-frame reset, optional test-pattern instance.
module tb_vga_pixel_pipe;

  localparam int HT = 14;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [9:0] x0, y0, x3, y3;
  logic       rv0, fs0, ls0, hs0, vs0;
  logic       rv3, fs3, ls3, hs3, vs3;
  logic [3:0] r0, g0, b0, r3, g3, b3;
  logic [3:0] pr3, pg3;
  logic [3:0] dr1 = '0, dr2 = '0, dr3 = '0;
  logic [3:0] dg1 = '0, dg2 = '0, dg3 = '0;

  vga_pixel_pipe #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .CW (4), .LAT (0), .CNT_W (10)
  ) u0 (
    .clk         (clk),
    .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
    .tp_en       (1'b0),
`endif
    .req_x       (x0),
    .req_y       (y0),
    .req_valid   (rv0),
    .pix_r       (x0[3:0]),
    .pix_g       (y0[3:0]),
    .pix_b       (4'h5),
    .frame_start (fs0),
    .line_start  (ls0),
    .VGA_HSYNC   (hs0),
    .VGA_VSYNC   (vs0),
    .VGA_R       (r0),
    .VGA_G       (g0),
    .VGA_B       (b0)
  );

  // Pixel source with a fixed 3-clock read latency.
  always @(posedge clk) begin
    dr1 <= x3[3:0];
    dr2 <= dr1;
    dr3 <= dr2;
    dg1 <= y3[3:0];
    dg2 <= dg1;
    dg3 <= dg2;
  end
  assign pr3 = dr3;
  assign pg3 = dg3;

  vga_pixel_pipe #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .CW (4), .LAT (3), .CNT_W (10)
  ) u3 (
    .clk         (clk),
    .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
    .tp_en       (1'b0),
`endif
    .req_x       (x3),
    .req_y       (y3),
    .req_valid   (rv3),
    .pix_r       (pr3),
    .pix_g       (pg3),
    .pix_b       (4'h5),
    .frame_start (fs3),
    .line_start  (ls3),
    .VGA_HSYNC   (hs3),
    .VGA_VSYNC   (vs3),
    .VGA_R       (r3),
    .VGA_G       (g3),
    .VGA_B       (b3)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] xt, yt;
  logic       rvt, fst, lst, hst, vst;
  logic [3:0] rt, gt, bt;

  vga_pixel_pipe #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .CW (4), .LAT (2), .CNT_W (10)
  ) ut (
    .clk         (clk),
    .reset       (reset),
    .tp_en       (1'b1),
    .req_x       (xt),
    .req_y       (yt),
    .req_valid   (rvt),
    .pix_r       (4'h3),
    .pix_g       (4'h3),
    .pix_b       (4'h3),
    .frame_start (fst),
    .line_start  (lst),
    .VGA_HSYNC   (hst),
    .VGA_VSYNC   (vst),
    .VGA_R       (rt),
    .VGA_G       (gt),
    .VGA_B       (bt)
  );
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Expected pins for the request issued at cycle m (m<0: idle).
  task automatic chk_pins(
    input string      tag,
    input int         m,
    input bit         tp,
    input logic       hs,
    input logic       vs,
    input logic [3:0] r,
    input logic [3:0] g,
    input logic [3:0] b
  );
    int h, v;
    logic act;
    logic [3:0] er, eg, eb;
    logic ehs, evs;
    ehs = 1'b1;
    evs = 1'b1;
    er = 4'h0;
    eg = 4'h0;
    eb = 4'h0;
    if (m >= 0) begin
      h = m % HT;
      v = (m / HT) % VT;
      act = (h < 8) && (v < 4);
      ehs = !((h >= 10) && (h < 13));
      evs = !((v >= 5) && (v < 7));
      if (act && tp) begin
        er = {4{h[2]}};
        eg = {4{h[1]}};
        eb = {4{h[0]}};
      end else if (act) begin
        er = h[3:0];
        eg = v[3:0];
        eb = 4'h5;
      end
    end
    chk({tag, ".hs"}, 32'(hs), 32'(ehs));
    chk({tag, ".vs"}, 32'(vs), 32'(evs));
    chk({tag, ".r"}, 32'(r), 32'(er));
    chk({tag, ".g"}, 32'(g), 32'(eg));
    chk({tag, ".b"}, 32'(b), 32'(eb));
  endtask

  // Cycle n counts samples since the first clock after release.
  task automatic chk_cycle(input int n);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    chk("u0.req_x", 32'(x0), 32'(h));
    chk("u0.req_y", 32'(y0), 32'(v));
    chk("u0.req_valid", 32'(rv0), 32'((h < 8) && (v < 4)));
    chk("u0.frame_start", 32'(fs0), 32'((h == 0) && (v == 0)));
    chk("u0.line_start", 32'(ls0), 32'(h == 0));
    chk("u3.req_x", 32'(x3), 32'(h));
    chk("u3.frame_start", 32'(fs3), 32'((h == 0) && (v == 0)));
    chk_pins("u0", n - 1, 1'b0, hs0, vs0, r0, g0, b0);
    chk_pins("u3", n - 4, 1'b0, hs3, vs3, r3, g3, b3);
`ifdef VGA_TEST_PATTERN_EN
    chk_pins("ut", n - 3, 1'b1, hst, vst, rt, gt, bt);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".hs0"}, 32'(hs0), 32'd1);
    chk({tag, ".vs0"}, 32'(vs0), 32'd1);
    chk({tag, ".rgb0"}, 32'({r0, g0, b0}), 32'd0);
    chk({tag, ".rv0"}, 32'(rv0), 32'd0);
    chk({tag, ".fs0"}, 32'(fs0), 32'd0);
    chk({tag, ".ls0"}, 32'(ls0), 32'd0);
    chk({tag, ".hs3"}, 32'(hs3), 32'd1);
    chk({tag, ".vs3"}, 32'(vs3), 32'd1);
    chk({tag, ".rgb3"}, 32'({r3, g3, b3}), 32'd0);
    chk({tag, ".rv3"}, 32'(rv3), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_reset("rst");

    reset = 1'b1;
    for (int n = 0; n <= 257; n++) begin
      @(posedge clk);
      #1;
      chk_cycle(n);
    end

    // Last sample above is request (5,2); abort the frame here.
    chk("abort.x", 32'(x0), 32'd5);
    chk("abort.y", 32'(y0), 32'd2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("mid");

    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      chk_cycle(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Parametrised VGA raster engine: generates horizontal/vertical timing for any mode, issues per-pixel coordinate requests to a pixel source (game logic, sprite ROM) with a fixed read latency, and realigns returned colour with delayed sync/blank so pins stay coherent. It replaces the fixed 640x480 display/timing stage between the 25 MHz pixel clock and the VGA connector, and generalises mode, colour width, sync polarity and source latency.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- HS_POL / VS_POL, 0 / 0, active level of HSYNC / VSYNC (0 = active-low)
- CW, 4, colour channel width
- LAT, 2, pixel-source read latency in clocks (0..7)
- CNT_W, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-low reset
- req_x  out  CNT_W  horizontal coordinate being requested
- req_y  out  CNT_W  vertical coordinate being requested
- req_valid  out  1  request coordinate lies in the active area
- pix_r / pix_g / pix_b  in  CW each  colour returned exactly LAT clocks after request
- frame_start  out  1  one-clock pulse when req (0,0) is issued
- line_start  out  1  one-clock pulse when req_x == 0
- VGA_HSYNC / VGA_VSYNC  out  1  sync outputs
- VGA_R / VGA_G / VGA_B  out  CW  blanked colour outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1, wraps to 0; v_cnt increments on h_cnt wrap, wraps 0 after V_TOTAL-1 (simultaneous wrap → both 0).
- req_x = h_cnt, req_y = v_cnt (registered, always driven); req_valid = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- HSYNC active while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; VSYNC active while V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (changes at line boundaries only).
- Sync and active flags travel through a LAT-stage shift register; at its tail, pix_* are sampled. Output register: RGB = active ? pix_* : 0; syncs converted to polarity.
- Reset (reset==0 at clk edge): h_cnt=v_cnt=0, pipeline cleared to inactive; outputs: VGA_HSYNC=~HS_POL, VGA_VSYNC=~VS_POL, RGB=0, frame_start=0, line_start=0, req_valid=0. Reset mid-frame aborts the frame; no partial line completes.
- First clock after release: req (0,0), req_valid=1, frame_start=1, line_start=1.

## Timing
- Request-to-pin latency: LAT+1 clocks for RGB and syncs alike; syncs never lead or trail colour.
- frame_start / line_start are request-side, coincident with req_x/req_y, not delayed.
- LAT=0: pix_* treated as combinational from req_x/req_y, sampled same cycle.
- No backpressure; the source must meet LAT every cycle.

## Configuration
- VGA_TEST_PATTERN_EN defined: extra input tp_en (1 bit). When tp_en=1, pix_* are ignored and 8 vertical colour bars of H_ACTIVE/8 pixels are shown; bar index b (0..7, left to right) gives R={CW{b[2]}}, G={CW{b[1]}}, B={CW{b[0]}}. Bar generator is delayed LAT stages so latency is unchanged. H_ACTIVE must be divisible by 8.
- Not defined: no tp_en port, no bar logic; colour always from pix_*.

## Structure
- Package vga_timing_pkg: 640x480@60 default constants, H_TOTAL/V_TOTAL computation function, colour-bar index constants.
- One sub-module: vga_sync_counter (h_cnt/v_cnt, active, raw sync flags, frame/line pulses). Pipeline and output stage stay in vga_pixel_pipe.

## Test plan
Small mode for all tests: H 8/2/3/1 (total 14), V 4/1/2/1 (total 8), CW=4.
- Reset held 5 clocks → HSYNC=VSYNC=1 (pol 0), RGB=0, req_valid=0, frame_start=0.
- Release, LAT=0 → frame_start pulses on first clock; HSYNC low for 3 clocks starting 11 clocks after h_cnt=0 (req_x=10 + 1); period 14 clocks.
- LAT=3, source returns pix_r=req_x[3:0] delayed 3 → VGA_R equals 0..7 then 0 during blanking, 4 clocks after each request; HSYNC edge shifted by 4 clocks consistently.
- VSYNC low for 2×14 clocks starting at v_cnt=5; frame period 112 clocks; frame_start every 112.
- Reset asserted at req (5,2) for 1 clock → next request (0,0) with frame_start=1; no stale colour on pins.
- VGA_TEST_PATTERN_EN, tp_en=1, H_ACTIVE=8 → VGA_R/G/B per pixel x: 000,001,...,111 bit-expanded to F/0.
